alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE -> EXEC -> RESP handshake FSM.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).

package decoder_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SR   = 4'd6,
      ALU_OR   = 4'd7,
      ALU_AND  = 4'd8
   } alu_op_t;
endpackage

module alu
   import decoder_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_t     op_i,
   input  logic        sub_arith_i,
   output logic [31:0] res_o
);

   // Unlisted encodings fall through to zero.
   always_comb begin
      res_o = '0;
      case (op_i)
         ALU_ADD:  res_o = a_i + b_i;
         ALU_SUB:  res_o = a_i - b_i;
         ALU_SLL:  res_o = a_i << b_i[4:0];
         ALU_SLT:  res_o = {31'd0, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: res_o = {31'd0, a_i < b_i};
         ALU_XOR:  res_o = a_i ^ b_i;
         ALU_SR:   res_o = sub_arith_i ? 32'($signed(a_i) >>> b_i[4:0]) : (a_i >> b_i[4:0]);
         ALU_OR:   res_o = a_i | b_i;
         ALU_AND:  res_o = a_i & b_i;
         default:  res_o = '0;
      endcase
   end

endmodule

module alu_arbiter
   import decoder_pkg::*;
#(
   parameter int unsigned RR_INIT = 0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  alu_op_t     req_op0,
   input  alu_op_t     req_op1,
   input  logic        req_sub0,
   input  logic        req_sub1,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_res,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q;
   logic [31:0] opA_q;
   logic [31:0] opB_q;
   alu_op_t     opCode_q;
   logic        opSub_q;
   logic        grantIdx_q;
   logic        grantIdx_d;
   logic        grantAny;
   logic [31:0] res_q;
   logic [1:0]  rspValid_q;
   logic        busy_q;
   logic [31:0] aluRes;
`ifdef ALU_ARBITER_RR_EN
   logic        prio_q;
`endif

   alu uAlu (
      .a_i         (opA_q),
      .b_i         (opB_q),
      .op_i        (opCode_q),
      .sub_arith_i (opSub_q),
      .res_o       (aluRes)
   );

   // Grant decision is combinational so req_ready rises in the same IDLE cycle as req_valid.
   always_comb begin
      grantAny   = (state_q == IDLE) && (req_valid != 2'b00);
`ifdef ALU_ARBITER_RR_EN
      grantIdx_d = (req_valid == 2'b11) ? prio_q : req_valid[1];
`else
      grantIdx_d = ~req_valid[0];
`endif
      req_ready  = 2'b00;
      if (grantAny) begin
         req_ready[grantIdx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         opA_q      <= '0;
         opB_q      <= '0;
         opCode_q   <= ALU_ADD;
         opSub_q    <= 1'b0;
         grantIdx_q <= 1'b0;
         res_q      <= '0;
         rspValid_q <= 2'b00;
         busy_q     <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
         prio_q     <= 1'(RR_INIT);
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (grantAny) begin
                  opA_q      <= grantIdx_d ? req_a1   : req_a0;
                  opB_q      <= grantIdx_d ? req_b1   : req_b0;
                  opCode_q   <= grantIdx_d ? req_op1  : req_op0;
                  opSub_q    <= grantIdx_d ? req_sub1 : req_sub0;
                  grantIdx_q <= grantIdx_d;
                  busy_q     <= 1'b1;
                  state_q    <= EXEC;
`ifdef ALU_ARBITER_RR_EN
                  prio_q     <= ~grantIdx_d;
`endif
               end
            end
            EXEC: begin
               res_q      <= aluRes;
               rspValid_q <= grantIdx_q ? 2'b10 : 2'b01;
               state_q    <= RESP;
            end
            RESP: begin
               if (rsp_ready[grantIdx_q]) begin
                  rspValid_q <= 2'b00;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               rspValid_q <= 2'b00;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_res   = res_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-requester ops plus hand-written
// sequences for simultaneous requests, response stall and reset during EXEC.

module tb_alu_arbiter;
   import decoder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [31:0] reqA0, reqB0, reqA1, reqB1;
   alu_op_t     reqOp0, reqOp1;
   logic        reqSub0, reqSub1;
   logic [1:0]  rspValid;
   logic [1:0]  rspReady;
   logic [31:0] rspRes;
   logic        busy;

   int checksTotal  = 0;
   int checksPassed = 0;

   typedef struct {
      string       name;
      logic        idx;
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] expRes;
   } vec_t;

   vec_t vectors[12];
   logic bothOrder[4];

   always #5 clk = ~clk;

   alu_arbiter #(.RR_INIT(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_a0    (reqA0),
      .req_b0    (reqB0),
      .req_a1    (reqA1),
      .req_b1    (reqB1),
      .req_op0   (reqOp0),
      .req_op1   (reqOp1),
      .req_sub0  (reqSub0),
      .req_sub1  (reqSub1),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_res   (rspRes),
      .busy      (busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic idx, input alu_op_t op, input logic [31:0] a,
                                input logic [31:0] b, input logic sub);
      if (idx) begin
         reqA1 = a; reqB1 = b; reqOp1 = op; reqSub1 = sub;
         reqValid = 2'b10;
      end else begin
         reqA0 = a; reqB0 = b; reqOp0 = op; reqSub0 = sub;
         reqValid = 2'b01;
      end
   endtask

   task automatic runVector(input string name, input logic idx, input alu_op_t op, input logic [31:0] a,
                            input logic [31:0] b, input logic sub, input logic [31:0] expRes);
      logic [1:0] oneHot;
      oneHot = idx ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      applyStimulus(idx, op, a, b, sub);
      @(negedge clk);
      checkOutput({name, ".ready"}, 32'(reqReady), 32'(oneHot));
      checkOutput({name, ".idleBusy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      reqValid = 2'b00;
      @(negedge clk);
      checkOutput({name, ".execBusy"}, 32'(busy), 32'd1);
      checkOutput({name, ".execValid"}, 32'(rspValid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({name, ".rspValid"}, 32'(rspValid), 32'(oneHot));
      checkOutput({name, ".rspRes"}, rspRes, expRes);
      rspReady = oneHot;
      @(posedge clk); #1;
      rspReady = 2'b00;
      @(negedge clk);
      checkOutput({name, ".doneValid"}, 32'(rspValid), 32'd0);
      checkOutput({name, ".doneBusy"}, 32'(busy), 32'd0);
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   initial begin
      vectors[0]  = '{"add",      1'b0, ALU_ADD,  32'd5,        32'd7,        1'b0, 32'd12};
      vectors[1]  = '{"sra",      1'b1, ALU_SR,   32'h80000000, 32'd4,        1'b1, 32'hF8000000};
      vectors[2]  = '{"srl",      1'b1, ALU_SR,   32'h80000000, 32'd4,        1'b0, 32'h08000000};
      vectors[3]  = '{"sub",      1'b0, ALU_SUB,  32'd3,        32'd5,        1'b0, 32'hFFFFFFFE};
      vectors[4]  = '{"sll",      1'b1, ALU_SLL,  32'd1,        32'h21,       1'b0, 32'd2};
      vectors[5]  = '{"sltu",     1'b0, ALU_SLTU, 32'd1,        32'd2,        1'b0, 32'd1};
      vectors[6]  = '{"slt",      1'b1, ALU_SLT,  32'hFFFFFFFF, 32'd1,        1'b0, 32'd1};
      vectors[7]  = '{"xor",      1'b0, ALU_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 32'h0F0FF0F0};
      vectors[8]  = '{"undef",    1'b1, alu_op_t'(4'hF), 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0};
      vectors[9]  = '{"and",      1'b0, ALU_AND,  32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 32'hF0F00000};
      vectors[10] = '{"or",       1'b1, ALU_OR,   32'hF0F0F0F0, 32'hFFFF0000, 1'b0, 32'hFFFFF0F0};
      vectors[11] = '{"addWrap",  1'b0, ALU_ADD,  32'hFFFFFFFF, 32'd2,        1'b0, 32'd1};
`ifdef ALU_ARBITER_RR_EN
      bothOrder = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      bothOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

      reset = 1'b0;
      reqValid = 2'b00; rspReady = 2'b00;
      reqA0 = '0; reqB0 = '0; reqA1 = '0; reqB1 = '0;
      reqOp0 = ALU_ADD; reqOp1 = ALU_ADD; reqSub0 = 1'b0; reqSub1 = 1'b0;
      #12;
      checkOutput("reset.ready", 32'(reqReady), 32'd0);
      checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
      checkOutput("reset.rspRes", rspRes, 32'd0);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      #10;
      reset = 1'b1;

      foreach (vectors[i]) begin
         runVector(vectors[i].name, vectors[i].idx, vectors[i].op, vectors[i].a,
                   vectors[i].b, vectors[i].sub, vectors[i].expRes);
      end

      // Simultaneous requests from a fresh reset: grant order depends on the arbitration build.
      pulseReset();
      @(posedge clk); #1;
      reqA0 = 32'd1; reqB0 = 32'd1; reqOp0 = ALU_ADD; reqSub0 = 1'b0;
      reqA1 = 32'd2; reqB1 = 32'd2; reqOp1 = ALU_ADD; reqSub1 = 1'b0;
      reqValid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("both%0d.ready", k), 32'(reqReady), bothOrder[k] ? 32'd2 : 32'd1);
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("both%0d.execReady", k), 32'(reqReady), 32'd0);
         @(posedge clk);
         @(negedge clk);
         checkOutput($sformatf("both%0d.rspValid", k), 32'(rspValid), bothOrder[k] ? 32'd2 : 32'd1);
         checkOutput($sformatf("both%0d.rspRes", k), rspRes, bothOrder[k] ? 32'd4 : 32'd2);
         rspReady = 2'b11;
         @(posedge clk); #1;
         rspReady = 2'b00;
      end
      reqValid = 2'b00;

      // Response stalled five cycles with competing traffic and a stray rsp_ready bit.
      @(posedge clk); #1;
      applyStimulus(1'b0, ALU_ADD, 32'd10, 32'd20, 1'b0);
      @(negedge clk);
      checkOutput("stall.ready", 32'(reqReady), 32'd1);
      @(posedge clk); #1;
      reqValid = 2'b11;
      rspReady = 2'b10;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d.rspValid", k), 32'(rspValid), 32'd1);
         checkOutput($sformatf("stall%0d.rspRes", k), rspRes, 32'd30);
         checkOutput($sformatf("stall%0d.ready", k), 32'(reqReady), 32'd0);
         @(posedge clk);
      end
      #1;
      reqValid = 2'b00;
      rspReady = 2'b01;
      @(posedge clk); #1;
      rspReady = 2'b00;
      @(negedge clk);
      checkOutput("stall.doneValid", 32'(rspValid), 32'd0);
      checkOutput("stall.doneBusy", 32'(busy), 32'd0);

      // Reset asserted mid-EXEC must drop the in-flight operation immediately.
      @(posedge clk); #1;
      applyStimulus(1'b0, ALU_SLTU, 32'd1, 32'd2, 1'b0);
      @(posedge clk); #1;
      reqValid = 2'b00;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rstExec.ready", 32'(reqReady), 32'd0);
      checkOutput("rstExec.rspValid", 32'(rspValid), 32'd0);
      checkOutput("rstExec.rspRes", rspRes, 32'd0);
      checkOutput("rstExec.busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rstExec%0d.rspValid", k), 32'(rspValid), 32'd0);
         checkOutput($sformatf("rstExec%0d.busy", k), 32'(busy), 32'd0);
      end
      runVector("afterReset", 1'b0, ALU_SLTU, 32'd1, 32'd2, 1'b0, 32'd1);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
